// File: rtl/c6502_bus.sv
// Bridge between the c6502 core and RAM, a local I/O page and a slow req/ack external region.
// RAM/IO accesses complete with no stall; external accesses hold cpu_ce low until ack or timeout.
module c6502_bus #(
    parameter logic [7:0] IO_PAGE  = 8'hBF,
    parameter logic [7:0] EXT_BASE = 8'hC0,
    parameter logic [7:0] TIMEOUT  = 8'd255
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic [15:0] cpu_address,
    input  logic [7:0]  cpu_out,
    input  logic        cpu_we,
    output logic [7:0]  cpu_in,
    output logic        cpu_ce,
    output logic [15:0] ram_address,
    output logic [7:0]  ram_data,
    output logic        ram_we,
    input  logic [7:0]  ram_q,
    output logic        ext_req,
    output logic        ext_we,
    output logic [15:0] ext_address,
    output logic [7:0]  ext_wdata,
    input  logic [7:0]  ext_rdata,
    input  logic        ext_ack
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;

    logic        r_ext_req;
    logic        r_ext_we;
    logic [15:0] r_ext_address;
    logic [7:0]  r_ext_wdata;
    logic [7:0]  r_rdat;
    logic [15:0] r_cnt;
    logic [7:0]  r_shadow;
    logic        r_tmo;
    logic [7:0]  r_wcnt;

    logic [7:0]  w_hi;
    logic [7:0]  w_io_off;
    logic        w_ext_hit;
    logic        w_io_hit;
    logic        w_idle_dec;
    logic        w_wait_last;
    logic [7:0]  w_io_rdata;

    assign w_hi        = cpu_address[15:8];
    assign w_io_off    = cpu_address[7:0];
    assign w_ext_hit   = (w_hi >= EXT_BASE);
    assign w_io_hit    = !w_ext_hit && (w_hi == IO_PAGE);
    // While reset is held the outputs decode as if idle, whatever the state register holds.
    assign w_idle_dec  = (r_state == S_IDLE) || !reset_n;
    assign w_wait_last = (r_wcnt == (TIMEOUT - 8'd1));

    assign ram_address = cpu_address;
    assign ram_data    = cpu_out;
    assign ext_req     = r_ext_req;
    assign ext_we      = r_ext_we;
    assign ext_address = r_ext_address;
    assign ext_wdata   = r_ext_wdata;

    always_comb begin
        w_io_rdata = 8'h00;
        case (w_io_off)
            8'h00:   w_io_rdata = r_cnt[7:0];
            8'h01:   w_io_rdata = r_shadow;
            8'h02:   w_io_rdata = {7'b0, r_tmo};
            default: w_io_rdata = 8'h00;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_ext_hit) w_state_nxt = S_WAIT;
            S_WAIT:  if (ext_ack || w_wait_last) w_state_nxt = S_DONE;
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        cpu_ce = 1'b1;
        cpu_in = 8'h00;
        ram_we = 1'b0;
        if (w_idle_dec) begin
            if (w_ext_hit) begin
                cpu_ce = 1'b0;
            end else if (w_io_hit) begin
                cpu_in = w_io_rdata;
            end else begin
                cpu_in = ram_q;
                ram_we = cpu_we && reset_n;
            end
        end else if (r_state == S_WAIT) begin
            cpu_ce = 1'b0;
            cpu_in = r_rdat;
        end else begin
            cpu_in = r_rdat;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_ext_req     <= 1'b0;
            r_ext_we      <= 1'b0;
            r_ext_address <= 16'h0000;
            r_ext_wdata   <= 8'h00;
            r_rdat        <= 8'h00;
            r_cnt         <= 16'h0000;
            r_shadow      <= 8'h00;
            r_tmo         <= 1'b0;
            r_wcnt        <= 8'h00;
        end else begin
            if (cpu_ce) begin
                r_cnt <= r_cnt + 16'd1;
            end
            case (r_state)
                S_IDLE: begin
                    if (w_ext_hit) begin
                        r_ext_req     <= 1'b1;
                        r_ext_we      <= cpu_we;
                        r_ext_address <= cpu_address;
                        r_ext_wdata   <= cpu_out;
                        r_wcnt        <= 8'h00;
                    end else if (w_io_hit) begin
                        if (w_io_off == 8'h00 && !cpu_we) begin
                            r_shadow <= r_cnt[15:8];
                        end
                        if (w_io_off == 8'h02 && cpu_we) begin
                            r_tmo <= 1'b0;
                        end
                    end
                end
                S_WAIT: begin
                    // Ack takes priority over a timeout landing in the same cycle.
                    if (ext_ack) begin
                        r_ext_req <= 1'b0;
                        if (!r_ext_we) begin
                            r_rdat <= ext_rdata;
                        end
                    end else if (w_wait_last) begin
                        r_ext_req <= 1'b0;
                        r_rdat    <= 8'hFF;
                        r_tmo     <= 1'b1;
                    end else begin
                        r_wcnt <= r_wcnt + 8'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_c6502_bus.sv
// Randomized scoreboard bench for c6502_bus: stimulus pushes expected responses, a monitor pops on each cpu_ce cycle.
module tb_c6502_bus;

    localparam int TMO = 255;

    logic        clock = 1'b0;
    logic        reset_n;
    logic [15:0] cpu_address;
    logic [7:0]  cpu_out;
    logic        cpu_we;
    logic [7:0]  cpu_in;
    logic        cpu_ce;
    logic [15:0] ram_address;
    logic [7:0]  ram_data;
    logic        ram_we;
    logic [7:0]  ram_q;
    logic        ext_req;
    logic        ext_we;
    logic [15:0] ext_address;
    logic [7:0]  ext_wdata;
    logic [7:0]  ext_rdata = 8'h00;
    logic        ext_ack = 1'b0;

    c6502_bus #(.IO_PAGE(8'hBF), .EXT_BASE(8'hC0), .TIMEOUT(8'd255)) dut (
        .clock(clock), .reset_n(reset_n),
        .cpu_address(cpu_address), .cpu_out(cpu_out), .cpu_we(cpu_we),
        .cpu_in(cpu_in), .cpu_ce(cpu_ce),
        .ram_address(ram_address), .ram_data(ram_data), .ram_we(ram_we), .ram_q(ram_q),
        .ext_req(ext_req), .ext_we(ext_we), .ext_address(ext_address), .ext_wdata(ext_wdata),
        .ext_rdata(ext_rdata), .ext_ack(ext_ack)
    );

    always #5 clock = ~clock;

    // RAM device: combinational read, write on the strobe.
    logic [7:0] mem [0:65535];
    assign ram_q = mem[ram_address];
    always @(posedge clock) if (ram_we) mem[ram_address] <= ram_data;

    typedef struct {
        logic [7:0] din;
        bit         chk_in;
        bit         wexp;
        int         stall;
    } exp_t;

    exp_t sb[$];
    int   n_chk = 0;
    int   n_fail = 0;

    // Reference model state.
    logic [7:0]  ref_mem [int];
    logic [15:0] m_cnt;
    logic [7:0]  m_shadow;
    logic        m_tmo;
    logic [7:0]  m_rdat;

    // External device plan for the current access.
    int          plan_dly = 0;
    int          plan_len = -1;
    logic [7:0]  plan_rdata = 8'h00;
    logic [15:0] plan_addr = 16'h0000;
    logic        plan_we = 1'b0;
    logic [7:0]  plan_wdata = 8'h00;

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, req, $time);
        end
    endtask

    // Monitor: counts stall cycles, pops and compares on every consumed cycle.
    int stall = 0;
    always @(negedge clock) begin : mon
        exp_t e;
        if (!reset_n) begin
            stall = 0;
        end else if (!cpu_ce) begin
            stall++;
            chk("ram_we_in_stall", ram_we, 1'b0);
        end else if (sb.size() == 0) begin
            n_chk++; n_fail++;
            $display("FAIL unexpected_ce: cpu_ce high with no access pending (t=%0t)", $time);
        end else begin
            e = sb.pop_front();
            chk("stall_cycles", 16'(stall), 16'(e.stall));
            chk("ram_we", ram_we, e.wexp);
            if (e.chk_in) chk("cpu_in", cpu_in, e.din);
            stall = 0;
        end
    end

    // External responder: acks in WAIT cycle plan_dly, toggles junk ack while idle.
    int widx = 0;
    always @(posedge clock) begin
        #1;
        if (ext_req) begin
            widx++;
            if (widx == 1) begin
                chk("ext_address", ext_address, plan_addr);
                chk("ext_we", ext_we, plan_we);
                if (plan_we) chk("ext_wdata", ext_wdata, plan_wdata);
            end
            ext_ack   = (widx == plan_dly);
            ext_rdata = ext_ack ? plan_rdata : 8'($urandom);
        end else begin
            if (widx > 0 && plan_len >= 0) chk("ext_req_len", 16'(widx), 16'(plan_len));
            widx      = 0;
            ext_ack   = ($urandom_range(0, 3) == 0);
            ext_rdata = 8'($urandom);
        end
    end

    task automatic model_reset();
        m_cnt = 16'h0000; m_shadow = 8'h00; m_tmo = 1'b0; m_rdat = 8'h00;
    endtask

    task automatic do_reset();
        reset_n = 1'b0; cpu_address = 16'h1000; cpu_we = 1'b1; cpu_out = 8'hEE;
        @(posedge clock);
        repeat (2) begin
            @(negedge clock);
            chk("rst_ram_we", ram_we, 1'b0);
            chk("rst_ext_req", ext_req, 1'b0);
            chk("rst_cpu_ce", cpu_ce, 1'b1);
        end
        @(posedge clock); #1;
        reset_n = 1'b1; cpu_we = 1'b0;
        model_reset();
    endtask

    // One CPU access: compute the expected response, present it, wait until consumed.
    task automatic access(input logic [15:0] a, input bit w, input logic [7:0] d,
                          input int dly, input logic [7:0] rd);
        exp_t e;
        bit   ok;
        e.chk_in = !w; e.wexp = 0; e.stall = 0; e.din = 8'h00;
        if (a[15:8] >= 8'hC0) begin
            plan_len = (dly >= 1 && dly <= TMO) ? dly : TMO;
            e.stall  = plan_len + 1;
            if (dly >= 1 && dly <= TMO) begin
                if (!w) m_rdat = rd;
            end else begin
                m_rdat = 8'hFF; m_tmo = 1'b1;
            end
            e.din = m_rdat;
            plan_dly = dly; plan_rdata = rd; plan_addr = a; plan_we = w; plan_wdata = d;
        end else if (a[15:8] == 8'hBF) begin
            case (a[7:0])
                8'h00: begin e.din = m_cnt[7:0]; if (!w) m_shadow = m_cnt[15:8]; end
                8'h01: e.din = m_shadow;
                8'h02: begin e.din = {7'b0, m_tmo}; if (w) m_tmo = 1'b0; end
                default: e.din = 8'h00;
            endcase
        end else begin
            e.wexp = w;
            if (w) ref_mem[int'(a)] = d;
            else if (ref_mem.exists(int'(a))) e.din = ref_mem[int'(a)];
            else e.chk_in = 0;
        end
        m_cnt = m_cnt + 16'd1;
        sb.push_back(e);
        cpu_address = a; cpu_we = w; cpu_out = d;
        ok = 0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clock);
            if (cpu_ce) begin ok = 1; break; end
        end
        if (!ok) begin
            n_chk++; n_fail++;
            $display("FAIL access_bound: addr %h never released cpu_ce, expected release", a);
            sb.delete();
        end
        @(posedge clock); #1;
    endtask

    function automatic logic [15:0] rand_addr(input int kind);
        if (kind < 5)      rand_addr = 16'h2000 + 16'($urandom_range(0, 15));
        else if (kind < 7) rand_addr = 16'hBF00 + 16'($urandom_range(0, 3));
        else               rand_addr = 16'hC000 + 16'($urandom_range(0, 16'h3FFF));
    endfunction

    initial begin
        int dly;
        int kind;
        cpu_address = 16'h0000; cpu_we = 1'b0; cpu_out = 8'h00; reset_n = 1'b0;
        model_reset();
        do_reset();

        // RAM write then read.
        access(16'h1234, 1, 8'h5A, 0, 8'h00);
        access(16'h1234, 0, 8'h00, 0, 8'h00);
        for (int i = 0; i < 16; i++) access(16'h2000 + 16'(i), 1, 8'($urandom), 0, 8'h00);

        // EXT read, ack in the fourth WAIT cycle.
        access(16'hC000, 0, 8'h00, 4, 8'hA7);
        // EXT write then read-back of unchanged rdat via another ext write path.
        access(16'hC123, 1, 8'h9C, 1, 8'h11);

        // Counter: 300 randomized accesses after reset, then BF00/BF01.
        do_reset();
        for (int i = 0; i < 300; i++) begin
            kind = $urandom_range(0, 9);
            dly  = ($urandom_range(0, 39) == 0) ? 0 : $urandom_range(1, 8);
            access(rand_addr(kind), bit'($urandom_range(0, 1)), 8'($urandom), dly, 8'($urandom));
        end
        access(16'hBF00, 0, 8'h00, 0, 8'h00);
        access(16'hBF01, 0, 8'h00, 0, 8'h00);

        // Timeout, sticky status, clear by write.
        access(16'hFFFC, 0, 8'h00, 0, 8'h00);
        access(16'hBF02, 0, 8'h00, 0, 8'h00);
        access(16'hBF02, 1, 8'h00, 0, 8'h00);
        access(16'hBF02, 0, 8'h00, 0, 8'h00);

        // Ack coincident with the timeout cycle.
        access(16'hE000, 0, 8'h00, TMO, 8'h33);
        access(16'hBF02, 0, 8'h00, 0, 8'h00);

        // Back-to-back external accesses with mixed ack delays.
        for (int i = 0; i < 20; i++)
            access(rand_addr(9), bit'($urandom_range(0, 1)), 8'($urandom), $urandom_range(1, 6), 8'($urandom));

        // Run the counter up to FFFF and across the wrap.
        while (m_cnt != 16'hFFFF) access(rand_addr(0), 0, 8'h00, 0, 8'h00);
        access(16'hBF00, 0, 8'h00, 0, 8'h00);
        access(16'hBF00, 0, 8'h00, 0, 8'h00);
        access(16'hBF01, 0, 8'h00, 0, 8'h00);

        // Reset in the middle of WAIT.
        plan_dly = 0; plan_len = -1; plan_addr = 16'hD000; plan_we = 1'b0; plan_wdata = 8'h00;
        cpu_address = 16'hD000; cpu_we = 1'b0;
        repeat (4) @(posedge clock);
        #1;
        chk("abort_req_before", ext_req, 1'b1);
        reset_n = 1'b0; cpu_address = 16'h1000;
        @(posedge clock); #1;
        chk("abort_req_after", ext_req, 1'b0);
        chk("abort_ce", cpu_ce, 1'b1);
        reset_n = 1'b1;
        model_reset();
        access(16'hBF00, 0, 8'h00, 0, 8'h00);
        access(16'hBF02, 0, 8'h00, 0, 8'h00);

        chk("sb_drained", 16'(sb.size()), 16'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/c6502_bus.md
# c6502_bus

Memory/bus bridge between the c6502 core and the rest of the system. Decodes every CPU address into on-chip RAM, a local I/O page (cycle counter, status) or a slow external region reached by a req/ack handshake. Stalls the core through `cpu_ce` while an external access is pending. Supplies `cpu_in` in the cycle the core consumes it.

## Interface
- `IO_PAGE`, default 8'hBF: high address byte of the local I/O page.
- `EXT_BASE`, default 8'hC0: addresses with `[15:8] >= EXT_BASE` go to the external region.
- `TIMEOUT`, default 255: wait-cycle limit for `ext_ack`; 8-bit, 1..255.
- `clock` in 1: system clock, all state on rising edge.
- `reset_n` in 1: reset, synchronous, active-low.
- `cpu_address` in 16: address from the core.
- `cpu_out` in 8: write data from the core.
- `cpu_we` in 1: write qualifier for the current address.
- `cpu_in` out 8: read data to the core.
- `cpu_ce` out 1: core clock enable.
- `ram_address` out 16: RAM address; equals `cpu_address`.
- `ram_data` out 8: RAM write data; equals `cpu_out`.
- `ram_we` out 1: RAM write strobe.
- `ram_q` in 8: RAM read data, valid in the same cycle as `ram_address`.
- `ext_req` out 1: external request, registered.
- `ext_we` out 1: external write, registered.
- `ext_address` out 16: external address, registered.
- `ext_wdata` out 8: external write data, registered.
- `ext_rdata` in 8: external read data, sampled on `ext_ack`.
- `ext_ack` in 1: external completion, one-cycle or level.

## Operation
Address decode uses `hi = cpu_address[15:8]`:
- EXT when `hi >= EXT_BASE`.
- IO when `hi == IO_PAGE`.
- RAM otherwise.

FSM states: IDLE, WAIT, DONE.

IDLE:
- `cpu_ce = !ext_hit`.
- RAM hit: `ram_we = cpu_we`, `cpu_in = ram_q`.
- IO hit: register access, `cpu_in` = register value; `ram_we = 0`.
- EXT hit: `cpu_ce = 0`. Latch `ext_address`, `ext_wdata` and `ext_we` from the CPU. Set `ext_req <= 1`, clear the wait counter, go to WAIT.

WAIT:
- `cpu_ce = 0`; `ext_req` stays 1.
- `ext_ack = 1`: `rdat <= ext_rdata` (reads only; writes leave `rdat`), `ext_req <= 0`, go to DONE.
- Otherwise the counter increments. When counter reaches `TIMEOUT` with no ack: `ext_req <= 0`, `rdat <= 8'hFF`, set sticky `tmo`, go to DONE.

DONE:
- `cpu_ce = 1`, `cpu_in = rdat`; go to IDLE.
- The next CPU address is decoded fresh in IDLE.

I/O page, offset = `cpu_address[7:0]`:
- 00: read returns `cnt[7:0]` and latches `shadow <= cnt[15:8]`.
- 01: read returns `shadow`.
- 02: read returns `{7'b0, tmo}`; any write clears `tmo`.
- Other offsets read 8'h00; writes to them, and to offsets 00/01, are ignored.

Side effects (shadow latch, tmo clear) occur only in cycles with `cpu_ce = 1`.

`cnt` is 16 bits. It increments on every clock with `cpu_ce = 1` and wraps FFFF→0000. A read of offset 00 returns the pre-increment value.

Outside the RAM region, and during reset, `ram_we = 0`.

## Timing
- Reset values: state IDLE, `ext_req = 0`, `ext_we = 0`, `ext_address = 0`, `ext_wdata = 0`, `rdat = 0`, `cnt = 0`, `shadow = 0`, `tmo = 0`, wait counter 0.
- During reset: `cpu_ce` and `cpu_in` follow IDLE decode; `ram_we` is forced to 0.
- RAM/IO access: zero stall; `cpu_ce` stays 1.
- EXT access: the EXT-detect cycle plus WAIT cycles plus DONE. With ack in the first WAIT cycle, `cpu_ce` is 0 for 2 cycles, then 1 for DONE.
- `ext_ack` arriving in the same cycle the timeout is reached: ack wins, real data is returned, `tmo` is not set.
- `ext_ack` seen outside WAIT is ignored.
- Reset mid-WAIT drops `ext_req` on the next edge; the aborted access is not retried.
- Back-to-back EXT accesses: `ext_req` is low for at least one cycle (DONE) between requests.
- Combinational paths: `cpu_address` → `cpu_ce`, `cpu_in`, `ram_we`. `ram_q` → `cpu_in`.

## Test plan
- RAM read/write: write 8'h5A to 1234 with `cpu_we = 1`, then read 1234 → `ram_we` pulses once, `cpu_in = ram_q`, `cpu_ce` never drops.
- EXT read, ack after 3 WAIT cycles with `ext_rdata = 8'hA7` at C000:
  - `ext_req` high for 4 cycles; `ext_address = C000`, `ext_we = 0`.
  - `cpu_ce` low for 5 cycles, then `cpu_in = A7` in DONE.
- EXT timeout at FFFC, no ack: `ext_req` drops after `TIMEOUT` wait cycles; DONE returns FF; read of BF02 → 01; write to BF02 then read → 00.
- Counter: after reset, 300 `cpu_ce` cycles, read BF00 → 8'h2C, then BF01 → 8'h01. Force `cnt` = FFFF and step one ce cycle → 0000.
- Ack coincident with the timeout cycle, `ext_rdata = 8'h33` → `cpu_in = 33`, `tmo` stays 0.
- Reset asserted in WAIT → next cycle `ext_req = 0`, state IDLE, `cnt = 0`.
